prbs_sym_gen: RTL and testbench
===============================

PRBS_SYM_GEN -- requirements
Module: prbs_sym_gen

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port sam_clk_en, input, 1 bit: sample-rate enable, one bit generated per pulse.
REQ-004 SHALL have port sym_clk_en, input, 1 bit: symbol-rate enable, asserted only together with every 4th sam_clk_en.
REQ-005 SHALL have port load_seed, input, 1 bit: synchronous reload of the LFSR seed.
REQ-006 SHALL have port inject_err, input, 1 bit: level input; each rising edge requests one symbol error.
REQ-007 SHALL have port sym_I, output, 2 bits: I symbol in slicer format.
REQ-008 SHALL have port sym_Q, output, 2 bits: Q symbol in slicer format.
REQ-009 SHALL have port amp_I, output, 18 bits signed 1s17: mapped I level.
REQ-010 SHALL have port amp_Q, output, 18 bits signed 1s17: mapped Q level.
REQ-011 SHALL have port window_start, output, 1 bit: one-cycle pulse at the start of each 2^20-symbol window.
REQ-012 SHALL have port inj_count, output, 16 bits: number of injected errors.

Function
REQ-013 SHALL hold a 22-bit Fibonacci LFSR q, seed 22'h3FFFFF, feedback bit b = q[21] XOR q[20].
REQ-014 On sam_clk_en: q <= {q[20:0], b}, and b SHALL shift into a 3-bit history register h <= {h[1:0], b}.
REQ-015 With sam_clk_en low, q and h SHALL hold.
REQ-016 load_seed high SHALL set q to 22'h3FFFFF and h to 0, with priority over sam_clk_en.
REQ-017 On sym_clk_en: {sym_I, sym_Q} SHALL be set to {h[2:0], b} using the current-cycle b. The oldest bit maps to sym_I[1] and the newest to sym_Q[0].
REQ-018 Latency: the symbol holding bits n..n+3 SHALL appear on the edge of the sam_clk_en that generates bit n+3.
REQ-019 amp_I/amp_Q SHALL be registered with sym_I/sym_Q using this map: 00 -> -98304, 01 -> -32768, 10 -> +32768, 11 -> +98304.
REQ-020 A 20-bit symbol counter SHALL increment on each sym_clk_en and wrap from 20'hFFFFF to 0.
REQ-021 window_start SHALL pulse for one cycle on the sym_clk_en at which the counter is 0.
REQ-022 Error injection SHALL use a rising-edge detector on inject_err, registered once, that sets an armed flag.
REQ-023 On the next sym_clk_en with the flag armed, sym_Q[0] SHALL be inverted, amp_Q SHALL be remapped from the inverted value, the flag SHALL clear, and inj_count SHALL increment.
REQ-024 A rising edge detected in the same cycle as sym_clk_en SHALL apply to the following symbol, not the current one.
REQ-025 Further edges while the flag is already armed SHALL be ignored (no queueing).
REQ-026 inj_count SHALL saturate at 16'hFFFF.
REQ-027 Injection SHALL NOT alter q or h, so the receiver's LFSR resynchronises.
REQ-028 load_seed SHALL also clear the symbol counter, so the next symbol starts a new window. It SHALL NOT clear inj_count or the armed flag.

Reset
REQ-029 When reset is high, the following SHALL apply asynchronously:
- q = 22'h3FFFFF, h = 0, symbol counter = 0;
- sym_I = sym_Q = 2'b00;
- amp_I = amp_Q = -98304;
- window_start = 0, inj_count = 0;
- armed flag and edge-detect register = 0.
REQ-030 After reset deasserts, the first sym_clk_en SHALL produce window_start = 1.
REQ-031 Reset asserted mid-symbol SHALL discard partial bits; no stale symbol SHALL be emitted after release.

Verification
REQ-032 Reset release, then 24 sam_clk_en pulses (sym_clk_en every 4th) -> symbols 1-5 = I 00 / Q 00, symbol 6 = I 01 / Q 00, amp_I = -32768; window_start only on symbol 1.
REQ-033 Run 2^20 + 1 symbols -> window_start pulses on symbol 1 and symbol 2^20+1 only.
REQ-034 inject_err rises once before symbol 6 -> symbol 6 = I 01 / Q 01, amp_Q = -32768, inj_count = 1; symbol 7 matches the error-free reference.
REQ-035 inject_err rises in the same cycle as sym_clk_en -> that symbol is unaltered and the next symbol has Q[0] inverted. Two edges before one symbol -> inj_count increments once.
REQ-036 load_seed after 100 symbols -> the sequence restarts identically to REQ-032 and the next symbol asserts window_start.
REQ-037 Loopback into the team BER checker, no injection -> error count 0. With 10 injections per window -> error count 30 (each flipped bit yields 3 errors through the 2-tap self-synchronising checker).

Source files
------------

// File: rtl/prbs_sym_gen.sv
`timescale 1ns/1ps
`default_nettype none
// prbs_sym_gen: PRBS-22 bit source grouped into 2-bit I / 2-bit Q symbols with a 4-level amplitude map,
//   a one-cycle window marker every 2^SYM_CNT_W symbols, and single-shot Q-LSB error injection.
// Latency: symbol bits n..n+3 register on the edge that generates bit n+3. Backpressure: none.
module prbs_sym_gen #(
  parameter int SYM_CNT_W = 20
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic               load_seed,
  input  logic               inject_err,
  output logic [1:0]         sym_I,
  output logic [1:0]         sym_Q,
  output logic signed [17:0] amp_I,
  output logic signed [17:0] amp_Q,
  output logic               window_start,
  output logic [15:0]        inj_count
);

  localparam logic [21:0] SEED = 22'h3FFFFF;

  // generator state
  logic [21:0]          r_q;
  logic [2:0]           r_h;
  logic [SYM_CNT_W-1:0] r_cnt;
  // error-injection state
  logic                 r_inj_d;
  logic                 r_armed;

  logic                 w_b;
  logic [3:0]           w_sym;
  logic                 w_rise;
  logic                 w_emit;
  logic                 w_inj;
  logic [1:0]           w_q_out;

  // Slicer code to 1s17 level: 00 -> -3/4, 01 -> -1/4, 10 -> +1/4, 11 -> +3/4 of full scale.
  function automatic logic signed [17:0] f_amp(input logic [1:0] s);
    case (s)
      2'b00:   f_amp = -18'sd98304;
      2'b01:   f_amp = -18'sd32768;
      2'b10:   f_amp = 18'sd32768;
      default: f_amp = 18'sd98304;
    endcase
  endfunction

  // Feedback bit of the current cycle; it is also the newest bit of a symbol emitted now.
  assign w_b     = r_q[21] ^ r_q[20];
  assign w_sym   = {r_h, w_b};
  assign w_rise  = inject_err & ~r_inj_d;
  // A seed reload owns the cycle: no symbol is emitted while the generator restarts.
  assign w_emit  = sym_clk_en & ~load_seed;
  // The flag is only consulted as registered, so an edge seen in a symbol cycle hits the next symbol.
  assign w_inj   = w_emit & r_armed;
  assign w_q_out = {w_sym[1], w_sym[0] ^ w_inj};

  // Edge-detect register for the level-sensitive inject request.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_inj_d <= 1'b0;
    end else begin
      r_inj_d <= inject_err;
    end
  end

  // Armed flag: consumed by the next emitted symbol; edges while armed are dropped, reload keeps it.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (w_inj) begin
      r_armed <= 1'b0;
    end else if (w_rise) begin
      r_armed <= 1'b1;
    end
  end

  // LFSR and 3-bit history advance one bit per sample strobe; reload wins over the strobe.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_q <= SEED;
      r_h <= 3'b000;
    end else if (load_seed) begin
      r_q <= SEED;
      r_h <= 3'b000;
    end else if (sam_clk_en) begin
      r_q <= {r_q[20:0], w_b};
      r_h <= {r_h[1:0], w_b};
    end
  end

  // Symbol counter: free-running modulo 2^SYM_CNT_W, restarted by a seed reload.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load_seed) begin
      r_cnt <= '0;
    end else if (sym_clk_en) begin
      r_cnt <= r_cnt + SYM_CNT_W'(1);
    end
  end

  // Symbol and amplitude registers; Q amplitude follows the possibly-corrupted Q code.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sym_I <= 2'b00;
      sym_Q <= 2'b00;
      amp_I <= -18'sd98304;
      amp_Q <= -18'sd98304;
    end else if (w_emit) begin
      sym_I <= w_sym[3:2];
      sym_Q <= w_q_out;
      amp_I <= f_amp(w_sym[3:2]);
      amp_Q <= f_amp(w_q_out);
    end
  end

  // Window marker: high for the single cycle following the symbol emitted at count zero.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      window_start <= 1'b0;
    end else begin
      window_start <= w_emit & (r_cnt == '0);
    end
  end

  // Injection counter, saturating so a long soak never reports a wrapped small number.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      inj_count <= 16'h0000;
    end else if (w_inj && (inj_count != 16'hFFFF)) begin
      inj_count <= inj_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs_sym_gen.sv
`timescale 1ns/1ps
// tb_prbs_sym_gen: directed stimulus with a queue of expected symbols checked by a separate monitor.
// The symbol counter is narrowed so window wrap fits in a short run.
module tb_prbs_sym_gen;

  localparam int CW  = 6;
  localparam int WIN = 1 << CW;

  logic               sys_clk = 1'b0;
  logic               reset = 1'b1;
  logic               sam_clk_en = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic               load_seed = 1'b0;
  logic               inject_err = 1'b0;
  logic [1:0]         sym_I;
  logic [1:0]         sym_Q;
  logic signed [17:0] amp_I;
  logic signed [17:0] amp_Q;
  logic               window_start;
  logic [15:0]        inj_count;

  prbs_sym_gen #(.SYM_CNT_W(CW)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .sam_clk_en   (sam_clk_en),
    .sym_clk_en   (sym_clk_en),
    .load_seed    (load_seed),
    .inject_err   (inject_err),
    .sym_I        (sym_I),
    .sym_Q        (sym_Q),
    .amp_I        (amp_I),
    .amp_Q        (amp_Q),
    .window_start (window_start),
    .inj_count    (inj_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]  i;
    logic [1:0]  q;
    logic [17:0] ai;
    logic [17:0] aq;
    logic        ws;
    logic [15:0] inj;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic fired = 1'b0;
  logic v [0:1199];
  logic [3:0] hand [0:10];
  int   nbits = 0;
  int   symno = 0;
  int   exp_inj = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [17:0] amp_of(input logic [1:0] s);
    case (s)
      2'b00:   amp_of = 18'h28000;   // -98304
      2'b01:   amp_of = 18'h38000;   // -32768
      2'b10:   amp_of = 18'h08000;   // +32768
      default: amp_of = 18'h18000;   // +98304
    endcase
  endfunction

  // Hand-worked first 11 symbols after a restart; later ones from the bit recurrence b[k]=b[k-22]^b[k-21].
  function automatic logic [3:0] bits_at(input int k);
    if ((k % 4 == 0) && (k / 4 < 11)) bits_at = hand[k / 4];
    else bits_at = {v[k + 22], v[k + 23], v[k + 24], v[k + 25]};
  endfunction

  // One sample strobe (optionally also a symbol strobe) followed by one idle cycle.
  task automatic pulse(input logic sym, input logic inj, input logic flip);
    exp_t       e;
    logic [3:0] s4;
    @(negedge sys_clk);
    sam_clk_en = 1'b1;
    sym_clk_en = sym;
    inject_err = inj;
    if (sym) begin
      s4 = bits_at(nbits - 3);
      if (flip) exp_inj++;
      e.i   = s4[3:2];
      e.q   = {s4[1], s4[0] ^ flip};
      e.ai  = amp_of(e.i);
      e.aq  = amp_of(e.q);
      e.ws  = ((symno % WIN) == 0);
      e.inj = 16'(exp_inj);
      sb.push_back(e);
      symno++;
    end
    nbits++;
    @(negedge sys_clk);
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
  endtask

  task automatic symbol(input logic [3:0] injpat, input logic flip);
    for (int p = 0; p < 4; p++) pulse(logic'(p == 3), injpat[p], flip);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_sym_I"}, 32'(sym_I), 32'h0);
    chk({tag, "_sym_Q"}, 32'(sym_Q), 32'h0);
    chk({tag, "_amp_I"}, {14'd0, amp_I}, 32'h28000);
    chk({tag, "_amp_Q"}, {14'd0, amp_Q}, 32'h28000);
    chk({tag, "_ws"}, 32'(window_start), 32'h0);
    chk({tag, "_inj"}, 32'(inj_count), 32'h0);
  endtask

  always @(posedge sys_clk or posedge reset) begin
    if (reset) fired <= 1'b0;
    else       fired <= sym_clk_en;
  end

  // Monitor: every symbol strobe must produce the next queued symbol; otherwise window_start stays low.
  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (fired) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_underflow: symbol output with no expected entry");
      end else begin
        e = sb.pop_front();
        chk("sym_I", 32'(sym_I), 32'(e.i));
        chk("sym_Q", 32'(sym_Q), 32'(e.q));
        chk("amp_I", {14'd0, amp_I}, 32'(e.ai));
        chk("amp_Q", {14'd0, amp_Q}, 32'(e.aq));
        chk("window_start", 32'(window_start), 32'(e.ws));
        chk("inj_count", 32'(inj_count), 32'(e.inj));
      end
    end else if (!reset) begin
      chk("ws_idle", 32'(window_start), 32'h0);
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: run did not complete, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int j = 0; j < 22; j++) v[j] = 1'b1;
    for (int j = 22; j < 1200; j++) v[j] = v[j - 22] ^ v[j - 21];
    for (int s = 0; s < 11; s++) hand[s] = 4'b0000;
    hand[5]  = 4'b0100;   // bit 21 is the first 1 of the sequence
    hand[10] = 4'b0011;   // bits 42 and 43

    // Reset state, then 11 clean symbols.
    repeat (3) @(negedge sys_clk);
    reset_checks("rst1");
    reset = 1'b0;
    for (int s = 1; s <= 11; s++) symbol(4'b0000, 1'b0);

    // Reset mid-symbol: partial bits discarded, outputs return to reset values.
    pulse(1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);
    @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    reset_checks("rst2");
    reset = 1'b0;
    nbits = 0;
    symno = 0;
    exp_inj = 0;

    for (int s = 1; s <= 5; s++) symbol(4'b0000, 1'b0);
    symbol(4'b0011, 1'b1);   // 6: edge on first bit -> Q[0] flipped
    symbol(4'b0000, 1'b0);   // 7: clean
    symbol(4'b1000, 1'b0);   // 8: edge on the symbol strobe itself -> unaltered
    symbol(4'b0011, 1'b1);   // 9: carries the injection from symbol 8
    symbol(4'b1101, 1'b1);   // 10: two edges, one injection
    symbol(4'b0000, 1'b0);   // 11: nothing queued
    for (int s = 12; s <= 100; s++) symbol(4'b0000, 1'b0);

    // Arm, then reload seed: the sequence and the window restart, flag and count survive.
    @(negedge sys_clk);
    inject_err = 1'b1;
    @(negedge sys_clk);
    load_seed = 1'b1;
    @(negedge sys_clk);
    load_seed = 1'b0;
    nbits = 0;
    symno = 0;
    symbol(4'b0000, 1'b1);
    for (int s = 2; s <= 11; s++) symbol(4'b0000, 1'b0);

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge sys_clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
